// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one holding slot per functional
// unit, at most one registered broadcast per cycle, flushed on squash.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash_signal,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU*XLEN-1:0]    fu_value,
  input  logic [NUM_FU-1:0]         fu_take_branch,
  input  logic [NUM_FU*XLEN-1:0]    fu_npc,
  output logic [NUM_FU-1:0]         fu_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [XLEN-1:0]           cdb_value,
  output logic                      cdb_take_branch,
  output logic [XLEN-1:0]           cdb_npc,
  output logic [$clog2(NUM_FU):0]   pending_cnt
);

  localparam int PTR_W = $clog2(NUM_FU);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
    logic             take_branch;
    logic [XLEN-1:0]  npc;
  } payload_t;

  payload_t              fu_pl   [NUM_FU];
  payload_t              slot_q  [NUM_FU];
  payload_t              cdb_q;
  logic [NUM_FU-1:0]     full_q;
  logic [NUM_FU-1:0]     grant;
  logic [NUM_FU-1:0]     fire;
  logic [PTR_W-1:0]      rr_ptr_q;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      next_ptr;
  logic                  any_grant;
  logic [CNT_W-1:0]      cnt;
  int                    idx;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_pl[i].tag         = fu_tag[i*TAG_W +: TAG_W];
      fu_pl[i].value       = fu_value[i*XLEN +: XLEN];
      fu_pl[i].take_branch = fu_take_branch[i];
      fu_pl[i].npc         = fu_npc[i*XLEN +: XLEN];
    end
  end

  // NOTE: combinational blocks use blocking assignments and give every output a
  // default before any branch, so no path can leave a latch behind.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_FU;
      if (!any_grant && full_q[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        win_idx    = PTR_W'(idx);
      end
    end
  end

  assign next_ptr = (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + PTR_W'(1);

  // A slot being drained this cycle may refill on the same edge.
  assign fu_ready = {NUM_FU{!squash_signal}} & (~full_q | grant);
  assign fire     = fu_valid & fu_ready;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_FU; i++) cnt = cnt + CNT_W'(full_q[i]);
  end
  assign pending_cnt = cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q    <= '0;
      rr_ptr_q  <= '0;
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
    end else if (squash_signal) begin
      full_q    <= '0;
      rr_ptr_q  <= '0;
      cdb_valid <= 1'b0;
    end else begin
      full_q    <= (full_q & ~grant) | fire;
      cdb_valid <= any_grant;
      if (any_grant) begin
        cdb_q    <= slot_q[win_idx];
        rr_ptr_q <= next_ptr;
      end
    end
  end

  // NOTE: slot payload storage has no reset; full_q alone qualifies it, which
  // keeps the wide data registers free of reset routing.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (fire[i]) slot_q[i] <= fu_pl[i];
    end
  end

  assign cdb_tag         = cdb_q.tag;
  assign cdb_value       = cdb_q.value;
  assign cdb_take_branch = cdb_q.take_branch;
  assign cdb_npc         = cdb_q.npc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a cycle-level reference model compared every cycle,
// plus directed scenarios with literal expectations (4-unit and 3-unit builds).
module tb_cdb_arbiter;

  localparam int N     = 4;
  localparam int N3    = 3;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic                    clock;
  logic                    reset;
  logic                    squash_signal;
  logic [N-1:0]            fu_valid;
  logic [N*TAG_W-1:0]      fu_tag;
  logic [N*XLEN-1:0]       fu_value;
  logic [N-1:0]            fu_take_branch;
  logic [N*XLEN-1:0]       fu_npc;
  logic [N-1:0]            fu_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;
  logic                    cdb_take_branch;
  logic [XLEN-1:0]         cdb_npc;
  logic [$clog2(N):0]      pending_cnt;

  logic [N3-1:0]           v3;
  logic [N3*TAG_W-1:0]     tag3;
  logic [N3*XLEN-1:0]      value3;
  logic [N3-1:0]           tb3;
  logic [N3*XLEN-1:0]      npc3;
  logic [N3-1:0]           ready3;
  logic                    cdb3_valid;
  logic [TAG_W-1:0]        cdb3_tag;
  logic [XLEN-1:0]         cdb3_value;
  logic                    cdb3_tb;
  logic [XLEN-1:0]         cdb3_npc;
  logic [$clog2(N3):0]     pending3;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.NUM_FU(N), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .squash_signal(squash_signal),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
    .fu_take_branch(fu_take_branch), .fu_npc(fu_npc), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_take_branch(cdb_take_branch), .cdb_npc(cdb_npc),
    .pending_cnt(pending_cnt)
  );

  cdb_arbiter #(.NUM_FU(N3), .XLEN(XLEN), .TAG_W(TAG_W)) dut3 (
    .clock(clock), .reset(reset), .squash_signal(1'b0),
    .fu_valid(v3), .fu_tag(tag3), .fu_value(value3),
    .fu_take_branch(tb3), .fu_npc(npc3), .fu_ready(ready3),
    .cdb_valid(cdb3_valid), .cdb_tag(cdb3_tag), .cdb_value(cdb3_value),
    .cdb_take_branch(cdb3_tb), .cdb_npc(cdb3_npc),
    .pending_cnt(pending3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic             m_full  [N];
  logic [TAG_W-1:0] m_tag   [N];
  logic [XLEN-1:0]  m_value [N];
  logic             m_tb    [N];
  logic [XLEN-1:0]  m_npc   [N];
  int               m_ptr;
  logic             m_cdb_valid;
  logic [TAG_W-1:0] m_cdb_tag;
  logic [XLEN-1:0]  m_cdb_value;
  logic             m_cdb_tb;
  logic [XLEN-1:0]  m_cdb_npc;
  int               mw;
  logic [N-1:0]     m_rdy;
  logic [N-1:0]     e_rdy;
  int               e_cnt;

  // Winner = occupied unit at the smallest circular distance from the pointer.
  function automatic int m_winner();
    int best = N;
    int w    = -1;
    for (int i = 0; i < N; i++) begin
      if (m_full[i] && ((i - m_ptr + N) % N) < best) begin
        best = (i - m_ptr + N) % N;
        w    = i;
      end
    end
    return w;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0; m_cdb_valid = 1'b0; m_cdb_tag = '0;
      m_cdb_value = '0; m_cdb_tb = 1'b0; m_cdb_npc = '0;
    end else if (squash_signal) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0; m_cdb_valid = 1'b0;
    end else begin
      mw = m_winner();
      for (int i = 0; i < N; i++) m_rdy[i] = !m_full[i] || (i == mw);
      if (mw >= 0) begin
        m_cdb_valid = 1'b1;
        m_cdb_tag   = m_tag[mw];
        m_cdb_value = m_value[mw];
        m_cdb_tb    = m_tb[mw];
        m_cdb_npc   = m_npc[mw];
        m_full[mw]  = 1'b0;
        m_ptr       = (mw + 1) % N;
      end else begin
        m_cdb_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (fu_valid[i] && m_rdy[i]) begin
          m_full[i]  = 1'b1;
          m_tag[i]   = fu_tag[i*TAG_W +: TAG_W];
          m_value[i] = fu_value[i*XLEN +: XLEN];
          m_tb[i]    = fu_take_branch[i];
          m_npc[i]   = fu_npc[i*XLEN +: XLEN];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset === 1'b1) begin
      mw    = m_winner();
      e_cnt = 0;
      for (int i = 0; i < N; i++) begin
        e_rdy[i] = !squash_signal && (!m_full[i] || (i == mw));
        e_cnt   += int'(m_full[i]);
      end
      check("m_ready", 64'(fu_ready), 64'(e_rdy));
      check("m_valid", 64'(cdb_valid), 64'(m_cdb_valid));
      check("m_pending", 64'(pending_cnt), 64'(e_cnt));
      if (m_cdb_valid) begin
        check("m_tag", 64'(cdb_tag), 64'(m_cdb_tag));
        check("m_value", 64'(cdb_value), 64'(m_cdb_value));
        check("m_tb", 64'(cdb_take_branch), 64'(m_cdb_tb));
        check("m_npc", 64'(cdb_npc), 64'(m_cdb_npc));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v,
                        input logic b, input logic [XLEN-1:0] n);
    fu_valid[i]                 = 1'b1;
    fu_tag[i*TAG_W +: TAG_W]    = t;
    fu_value[i*XLEN +: XLEN]    = v;
    fu_take_branch[i]           = b;
    fu_npc[i*XLEN +: XLEN]      = n;
  endtask

  task automatic set_fu3(input int i, input logic [TAG_W-1:0] t);
    v3[i]                    = 1'b1;
    tag3[i*TAG_W +: TAG_W]   = t;
    value3[i*XLEN +: XLEN]   = XLEN'(32'h300 + i);
    tb3[i]                   = 1'b0;
    npc3[i*XLEN +: XLEN]     = XLEN'(32'h3000 + i);
  endtask

  int           k_cnt [N];
  int           bcast;
  logic [N-1:0] fired;

  initial begin
    reset = 1'b0; squash_signal = 1'b0;
    fu_valid = '0; fu_tag = '0; fu_value = '0; fu_take_branch = '0; fu_npc = '0;
    v3 = '0; tag3 = '0; value3 = '0; tb3 = '0; npc3 = '0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("rst_valid", 64'(cdb_valid), 64'(0));
    check("rst_tag", 64'(cdb_tag), 64'(0));
    check("rst_value", 64'(cdb_value), 64'(0));
    check("rst_npc", 64'(cdb_npc), 64'(0));
    check("rst_pending", 64'(pending_cnt), 64'(0));
    check("rst_ready", 64'(fu_ready), 64'(4'b1111));

    // Single result from unit 2.
    set_fu(2, 5'd7, 32'hDEADBEEF, 1'b1, 32'h104);
    step(); fu_valid = '0;
    check("single_pending", 64'(pending_cnt), 64'(1));
    check("single_nobcast", 64'(cdb_valid), 64'(0));
    step();
    check("single_valid", 64'(cdb_valid), 64'(1));
    check("single_tag", 64'(cdb_tag), 64'(7));
    check("single_value", 64'(cdb_value), 64'(32'hDEADBEEF));
    check("single_tb", 64'(cdb_take_branch), 64'(1));
    check("single_npc", 64'(cdb_npc), 64'(32'h104));
    step();
    check("single_done", 64'(cdb_valid), 64'(0));

    // Pointer now at 3: a full set drains 3,0,1,2.
    for (int i = 0; i < N; i++) set_fu(i, TAG_W'(20 + i), XLEN'(32'h500 + i), 1'b0, XLEN'(32'h5000 + i));
    step(); fu_valid = '0;
    check("ptr3_pending", 64'(pending_cnt), 64'(4));
    step(); check("ptr3_first", 64'(cdb_tag), 64'(23));
    step(); check("ptr3_second", 64'(cdb_tag), 64'(20));
    step(); check("ptr3_third", 64'(cdb_tag), 64'(21));
    step(); check("ptr3_fourth", 64'(cdb_tag), 64'(22));
    step(); check("ptr3_idle", 64'(cdb_valid), 64'(0));

    // Squash with slots 0,1,3 full and unit 2 offering a result.
    set_fu(0, 5'd10, 32'hA0, 1'b0, 32'hA00);
    set_fu(1, 5'd11, 32'hA1, 1'b0, 32'hA01);
    set_fu(3, 5'd13, 32'hA3, 1'b0, 32'hA03);
    step(); fu_valid = '0;
    squash_signal = 1'b1;
    set_fu(2, 5'd12, 32'hA2, 1'b1, 32'hA02);
    #1;
    check("sq_ready", 64'(fu_ready), 64'(0));
    check("sq_pending_before", 64'(pending_cnt), 64'(3));
    step(); squash_signal = 1'b0; fu_valid = '0;
    check("sq_pending", 64'(pending_cnt), 64'(0));
    check("sq_valid", 64'(cdb_valid), 64'(0));
    for (int j = 0; j < 3; j++) begin
      step(); check("sq_no_stale", 64'(cdb_valid), 64'(0));
    end

    // Fairness: every unit offers every cycle; grants must rotate 0,1,2,3,...
    for (int i = 0; i < N; i++) k_cnt[i] = 0;
    bcast = 0;
    for (int j = 0; j < 14; j++) begin
      for (int i = 0; i < N; i++)
        set_fu(i, TAG_W'(4*i + k_cnt[i]), XLEN'(i*256 + k_cnt[i]), k_cnt[i][0], XLEN'(32'h1000 + 16*i + k_cnt[i]));
      #1;
      fired = fu_valid & fu_ready;
      step();
      for (int i = 0; i < N; i++) k_cnt[i] += int'(fired[i]);
      if (cdb_valid) begin
        check("rr_order", 64'(cdb_value >> 8), 64'(bcast % N));
        bcast++;
      end
    end
    check("rr_count", 64'(bcast), 64'(13));
    fu_valid = '0;
    repeat (6) step();

    // Grant-and-refill on unit 1 (pointer is at 1 here).
    set_fu(1, 5'd3, 32'h33, 1'b0, 32'h330);
    step();
    set_fu(1, 5'd9, 32'h99, 1'b1, 32'h990);
    #1;
    check("refill_ready", 64'(fu_ready), 64'(4'b1111));
    step(); fu_valid = '0;
    check("refill_old_tag", 64'(cdb_tag), 64'(3));
    check("refill_pending", 64'(pending_cnt), 64'(1));
    step();
    check("refill_new_valid", 64'(cdb_valid), 64'(1));
    check("refill_new_tag", 64'(cdb_tag), 64'(9));
    check("refill_new_pend", 64'(pending_cnt), 64'(0));
    step();
    check("refill_idle", 64'(cdb_valid), 64'(0));

    // Asynchronous reset with slots 0 and 2 full and a broadcast on the bus.
    set_fu(0, 5'd1, 32'h11, 1'b0, 32'h110);
    set_fu(2, 5'd2, 32'h22, 1'b0, 32'h220);
    step(); fu_valid = '0;
    set_fu(2, 5'd6, 32'h66, 1'b0, 32'h660);
    step(); fu_valid = '0;
    check("mid_pending", 64'(pending_cnt), 64'(2));
    check("mid_valid", 64'(cdb_valid), 64'(1));
    check("mid_tag", 64'(cdb_tag), 64'(2));
    #2 reset = 1'b0;
    #1;
    check("async_valid", 64'(cdb_valid), 64'(0));
    check("async_pending", 64'(pending_cnt), 64'(0));
    check("async_ready", 64'(fu_ready), 64'(4'b1111));
    check("async_tag", 64'(cdb_tag), 64'(0));
    step(); reset = 1'b1;
    step();
    check("post_rst_valid", 64'(cdb_valid), 64'(0));

    // Three-unit build: pointer to 2, then 0 and 1 full, 2 empty.
    set_fu3(1, 5'd5);
    step(); v3 = '0;
    step(); check("w3_setup_tag", 64'(cdb3_tag), 64'(5));
    step(); check("w3_setup_idle", 64'(cdb3_valid), 64'(0));
    set_fu3(0, 5'd6);
    set_fu3(1, 5'd8);
    step(); v3 = '0;
    check("w3_pending", 64'(pending3), 64'(2));
    step();
    check("w3_first_valid", 64'(cdb3_valid), 64'(1));
    check("w3_first_tag", 64'(cdb3_tag), 64'(6));
    check("w3_first_pend", 64'(pending3), 64'(1));
    step();
    check("w3_second_tag", 64'(cdb3_tag), 64'(8));
    check("w3_second_val", 64'(cdb3_value), 64'(32'h301));
    step();
    check("w3_idle", 64'(cdb3_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
